// File: rtl/clk_enable_bank_if.sv
// Configuration and enable-pulse bundle for clk_enable_bank.
// The master side drives configuration and run controls. The slave side returns the pulses and status.
interface clk_enable_bank_if #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 cfg_we;
    logic [CH_W-1:0]      cfg_ch;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 cfg_oneshot;
    logic [NUM_CH-1:0]    ch_enable;
    logic                 sync_restart;
    logic [NUM_CH-1:0]    clk_en;
    logic [NUM_CH-1:0]    busy;
    logic                 cfg_err;

    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_oneshot, ch_enable, sync_restart,
        input  clk_en, busy, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_oneshot, ch_enable, sync_restart,
        output clk_en, busy, cfg_err
    );
endinterface

// File: rtl/clk_enable_bank.sv
// A bank of independent clock-enable dividers. Each channel emits a one-cycle pulse every div+1 enabled cycles.
// A channel runs either periodically or as a one-shot.
module clk_enable_bank #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16,
    parameter int RESET_DIV = 0
) (
    input  logic             clk_in,
    input  logic             reset_in,
    clk_enable_bank_if.slave bus
);
    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);

    logic [DIV_WIDTH-1:0] cnt_q  [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_d  [NUM_CH];
    logic [DIV_WIDTH-1:0] div_q  [NUM_CH];
    logic [DIV_WIDTH-1:0] div_d  [NUM_CH];
    logic [DIV_WIDTH-1:0] pdiv_q [NUM_CH];
    logic [DIV_WIDTH-1:0] pdiv_d [NUM_CH];

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] pmode_q, pmode_d;
    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [NUM_CH-1:0] clk_en_q, clk_en_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cfg_valid;
    logic [NUM_CH-1:0] wr_hit, run, tc;

    always_comb begin
        cfg_valid = bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH);
        cfg_err_d = bus.cfg_we && !cfg_valid;

        cnt_d    = cnt_q;
        div_d    = div_q;
        pdiv_d   = pdiv_q;
        pend_d   = pend_q;
        mode_d   = mode_q;
        pmode_d  = pmode_q;
        armed_d  = armed_q;
        clk_en_d = '0;
        wr_hit   = '0;
        run      = '0;
        tc       = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = cfg_valid && (int'(bus.cfg_ch) == i);
            run[i]    = bus.ch_enable[i] && armed_q[i];
            tc[i]     = run[i] && (cnt_q[i] == div_q[i]);

            if (bus.sync_restart) begin
                cnt_d[i]   = '0;
                armed_d[i] = 1'b1;
                pend_d[i]  = 1'b0;
                if (wr_hit[i]) begin
                    div_d[i]  = bus.cfg_div;
                    mode_d[i] = bus.cfg_oneshot;
                end else if (pend_q[i]) begin
                    div_d[i]  = pdiv_q[i];
                    mode_d[i] = pmode_q[i];
                end
            end else if (wr_hit[i] && !run[i]) begin
                cnt_d[i]   = '0;
                div_d[i]   = bus.cfg_div;
                mode_d[i]  = bus.cfg_oneshot;
                pend_d[i]  = 1'b0;
                armed_d[i] = 1'b1;
            end else if (tc[i]) begin
                clk_en_d[i] = 1'b1;
                cnt_d[i]    = '0;
                if (wr_hit[i]) begin
                    div_d[i]  = bus.cfg_div;
                    mode_d[i] = bus.cfg_oneshot;
                    pend_d[i] = 1'b0;
                end else if (pend_q[i]) begin
                    div_d[i]  = pdiv_q[i];
                    mode_d[i] = pmode_q[i];
                    pend_d[i] = 1'b0;
                end
                // The mode of the period that just ended decides disarm; a write landing here re-arms.
                armed_d[i] = !mode_q[i] || wr_hit[i];
            end else if (run[i]) begin
                cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
                if (wr_hit[i]) begin
                    pdiv_d[i]  = bus.cfg_div;
                    pmode_d[i] = bus.cfg_oneshot;
                    pend_d[i]  = 1'b1;
                end
            end
        end

        busy_d = armed_d & bus.ch_enable;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= RST_DIV;
                pdiv_q[i] <= '0;
            end
            pend_q    <= '0;
            mode_q    <= '0;
            pmode_q   <= '0;
            armed_q   <= '1;
            clk_en_q  <= '0;
            busy_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pdiv_q    <= pdiv_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            pmode_q   <= pmode_d;
            armed_q   <= armed_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.clk_en  = clk_en_q;
    assign bus.busy    = busy_q;
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_clk_enable_bank.sv
// Directed bench for clk_enable_bank: a vector table plus hand sequences for multi-cycle cases.
module tb_clk_enable_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_enable_bank_if #(.NUM_CH(4), .DIV_WIDTH(16)) bi ();
    clk_enable_bank_if #(.NUM_CH(3), .DIV_WIDTH(4))  bj ();

    clk_enable_bank #(.NUM_CH(4), .DIV_WIDTH(16), .RESET_DIV(0)) u_dut (
        .clk_in(clk), .reset_in(rst), .bus(bi)
    );
    clk_enable_bank #(.NUM_CH(3), .DIV_WIDTH(4), .RESET_DIV(0)) u_dut3 (
        .clk_in(clk), .reset_in(rst), .bus(bj)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic [15:0] dv;
        logic        os;
        logic [3:0]  en;
        logic        sy;
        logic [3:0]  exp_ce;
        logic [3:0]  exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic [15:0] dv,
                                input logic [3:0] en, input logic [3:0] ce, input logic [3:0] bz);
        vec_t v;
        v.we = we; v.ch = ch; v.dv = dv; v.os = 1'b0; v.en = en; v.sy = 1'b0;
        v.exp_ce = ce; v.exp_busy = bz; v.exp_err = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input logic [1:0] ch, input logic [15:0] dv,
                       input logic os, input logic [3:0] en, input logic sy);
        bi.cfg_we = we; bi.cfg_ch = ch; bi.cfg_div = dv;
        bi.cfg_oneshot = os; bi.ch_enable = en; bi.sync_restart = sy;
    endtask

    initial begin
        // Periodic ch0 div=3, then ch1 div=0 with a 3-cycle pause.
        vt[0]  = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vt[1]  = mk(1, 0, 3, 4'b0000, 4'b0000, 4'b0000);
        vt[2]  = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[3]  = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[4]  = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[5]  = mk(0, 0, 0, 4'b0001, 4'b0001, 4'b0001);
        vt[6]  = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[7]  = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[8]  = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[9]  = mk(0, 0, 0, 4'b0001, 4'b0001, 4'b0001);
        vt[10] = mk(1, 1, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[11] = mk(0, 0, 0, 4'b0011, 4'b0010, 4'b0011);
        vt[12] = mk(0, 0, 0, 4'b0011, 4'b0010, 4'b0011);
        vt[13] = mk(0, 0, 0, 4'b0011, 4'b0011, 4'b0011);
        vt[14] = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[15] = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[16] = mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
        vt[17] = mk(0, 0, 0, 4'b0011, 4'b0011, 4'b0011);
        vt[18] = mk(0, 0, 0, 4'b0011, 4'b0010, 4'b0011);
        vt[19] = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

        rst = 1'b1;
        drv(0, 0, 0, 0, 4'b0000, 0);
        bj.cfg_we = 1'b0; bj.cfg_ch = '0; bj.cfg_div = '0;
        bj.cfg_oneshot = 1'b0; bj.ch_enable = '0; bj.sync_restart = 1'b0;
        tick;
        tick;
        chk("rst_ce",    bi.clk_en,  0);
        chk("rst_busy",  bi.busy,    0);
        chk("rst_err",   bi.cfg_err, 0);
        chk("rst3_ce",   bj.clk_en,  0);
        chk("rst3_busy", bj.busy,    0);
        chk("rst3_err",  bj.cfg_err, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drv(vt[i].we, vt[i].ch, vt[i].dv, vt[i].os, vt[i].en, vt[i].sy);
            tick;
            chk($sformatf("vec%0d_ce", i),   bi.clk_en,  vt[i].exp_ce);
            chk($sformatf("vec%0d_busy", i), bi.busy,    vt[i].exp_busy);
            chk($sformatf("vec%0d_err", i),  bi.cfg_err, vt[i].exp_err);
        end

        // ch2 div=9, rewritten to div=2 at cnt=4: pulses at enabled edges 10, 13, 16.
        drv(1, 2, 9, 0, 4'b0000, 0);
        tick;
        for (int e = 1; e <= 16; e++) begin
            drv(e == 5, 2, 2, 0, 4'b0100, 0);
            tick;
            chk($sformatf("pend_e%0d", e), bi.clk_en,
                (e == 10 || e == 13 || e == 16) ? 4'b0100 : 4'b0000);
        end
        drv(0, 0, 0, 0, 4'b0000, 0);
        tick;

        // ch3 one-shot div=5, twice.
        drv(1, 3, 5, 1, 4'b0000, 0);
        tick;
        for (int r = 0; r < 2; r++) begin
            for (int e = 1; e <= 10; e++) begin
                drv(0, 0, 0, 0, 4'b1000, 0);
                tick;
                chk($sformatf("os%0d_ce_e%0d", r, e), bi.clk_en, (e == 6) ? 4'b1000 : 4'b0000);
                chk($sformatf("os%0d_busy_e%0d", r, e), bi.busy, (e < 6) ? 4'b1000 : 4'b0000);
            end
            if (r == 0) begin
                drv(1, 3, 5, 1, 4'b1000, 0);
                tick;
                chk("os_rearm_busy", bi.busy, 4'b1000);
                chk("os_rearm_ce",   bi.clk_en, 4'b0000);
            end
        end

        // Divisors 2,4,6 running out of phase, then sync_restart.
        drv(0, 0, 0, 0, 4'b0000, 0);
        tick;
        drv(1, 0, 2, 0, 4'b0000, 0); tick;
        drv(1, 1, 4, 0, 4'b0000, 0); tick;
        drv(1, 2, 6, 0, 4'b0000, 0); tick;
        for (int e = 0; e < 5; e++) begin
            drv(0, 0, 0, 0, 4'b0111, 0);
            tick;
        end
        drv(0, 0, 0, 0, 4'b0111, 1);
        tick;
        chk("sync_ce",   bi.clk_en, 4'b0000);
        chk("sync_busy", bi.busy,   4'b0111);
        for (int e = 1; e <= 8; e++) begin
            drv(0, 0, 0, 0, 4'b0111, 0);
            tick;
            chk($sformatf("sync_e%0d", e), bi.clk_en,
                {1'b0, e == 7, e == 5, (e % 3) == 0});
        end

        // Pending ch2 div=1 applied by sync; simultaneous write to ch0 div=4 wins for ch0.
        drv(1, 2, 1, 0, 4'b0111, 0);
        tick;
        drv(1, 0, 4, 0, 4'b0111, 1);
        tick;
        chk("sync_wr_ce", bi.clk_en, 4'b0000);
        for (int e = 1; e <= 10; e++) begin
            drv(0, 0, 0, 0, 4'b0111, 0);
            tick;
            chk($sformatf("syncwr_e%0d", e), bi.clk_en,
                {1'b0, (e % 2) == 0, (e % 5) == 0, (e % 5) == 0});
        end

        // NUM_CH=3, DIV_WIDTH=4: max divisor, continuous ch1, and a write to missing channel 3.
        bj.cfg_we = 1'b1; bj.cfg_ch = 2'd0; bj.cfg_div = 4'd15; bj.ch_enable = 3'b000;
        tick;
        for (int e = 1; e <= 20; e++) begin
            bj.cfg_we = (e == 3); bj.cfg_ch = 2'd3; bj.cfg_div = 4'd5; bj.ch_enable = 3'b011;
            tick;
            chk($sformatf("n3_ce_e%0d", e), bj.clk_en, {2'b01, e == 16});
            chk($sformatf("n3_err_e%0d", e), bj.cfg_err, e == 3);
            chk($sformatf("n3_busy_e%0d", e), bj.busy, 3'b011);
        end
        bj.cfg_we = 1'b0;

        // Pending write then reset mid-period: pending discarded, div back to 0.
        drv(1, 2, 5, 0, 4'b0111, 0);
        tick;
        rst = 1'b1;
        drv(0, 0, 0, 0, 4'b0111, 0);
        tick;
        chk("mrst_ce",    bi.clk_en,  0);
        chk("mrst_busy",  bi.busy,    0);
        chk("mrst_err",   bi.cfg_err, 0);
        chk("mrst3_ce",   bj.clk_en,  0);
        chk("mrst3_busy", bj.busy,    0);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            drv(0, 0, 0, 0, 4'b0100, 0);
            tick;
            chk($sformatf("post_rst_e%0d", e), bi.clk_en, 4'b0100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
